mem_bridge_master: RTL
======================

Name: mem_bridge_master

Overview:
- CPU-side initiator for the shadowed 64K main-memory bridge. It drives address, data, MemBridge_Load and MemBridge_Direction, then waits for Memory_Ack.
- It sequences the boot shadow copy by holding ResetReq until the copy window expires.
- It sits between the pipeline load/store stage and the memory bus. It accepts one request at a time and returns one response per request.

Parameters:
- COPY_CYCLES, 32768: cycles ResetReq stays high after reset (shadow copy window). Range 1..65535.
- TIMEOUT, 15: WAIT_ACK cycles before a transaction is aborted with error. Range 1..255.

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req_Valid  in  1  pipeline request present.
- Req_Ready  out  1  block can accept a request.
- Req_Write  in  1  1 = write, 0 = read.
- Req_Addr  in  16  request address.
- Req_WData  in  8  write data.
- Rsp_Valid  out  1  one-cycle response strobe.
- Rsp_RData  out  8  read data; 0xFF on error.
- Rsp_Error  out  1  ack timeout; valid with Rsp_Valid.
- Addr  out  16  memory bus address.
- MemData_Out  out  8  write data to bus; top level combines with MemData_OE into inout MEMDATA.
- MemData_OE  out  1  drive MEMDATA.
- MemData_In  in  8  MEMDATA read value.
- MemBridge_Load  out  1  transaction start strobe.
- MemBridge_Direction  out  1  1 = write to memory, 0 = read.
- Memory_Ack  in  1  memory completion.
- ResetReq  out  1  shadow copy request to memory.
- Copy_Busy  out  1  high while in BOOT.

Behaviour:
- All outputs are registered.
- Reset values:
  - ResetReq=1, Copy_Busy=1.
  - All other outputs 0.
  - State = BOOT; counters = 0.
- States:
  - BOOT: ResetReq=1, Copy_Busy=1, Req_Ready=0. Copy counter increments each cycle. After exactly COPY_CYCLES rising edges with Reset low, go to IDLE with ResetReq=0, Copy_Busy=0, Req_Ready=1.
  - IDLE: Req_Ready=1. On Req_Valid at edge T:
    - latch Addr<=Req_Addr, MemData_Out<=Req_WData, MemBridge_Direction<=Req_Write, MemData_OE<=Req_Write;
    - MemBridge_Load<=1, Req_Ready<=0;
    - go to LOAD.
  - LOAD (cycle after T): MemBridge_Load=1 for exactly one cycle. Memory_Ack is sampled here.
    - Ack high: go to RESP.
    - Otherwise: go to WAIT_ACK with timeout counter = 0.
  - WAIT_ACK: MemBridge_Load=0; Addr, MemData_Out, Direction and OE held stable. Timeout counter increments each cycle.
    - Ack high: go to RESP.
    - Counter reaches TIMEOUT-1 without ack: go to RESP with error.
    - Ack on the timeout cycle wins (no error).
  - RESP: Rsp_Valid=1 for one cycle. MemData_OE=0, MemBridge_Direction=0.
    - Read: Rsp_RData = MemData_In registered on the ack edge.
    - Write: Rsp_RData=0.
    - Error: Rsp_Error=1, Rsp_RData=0xFF.
    - Next state IDLE with Req_Ready=1. Rsp_Error clears with Rsp_Valid.
- Latency:
  - Zero-wait ack (ack in LOAD): Rsp_Valid at T+2, Req_Ready high again at T+3.
  - Each WAIT_ACK cycle adds one cycle.
- No response backpressure. The pipeline must consume Rsp_Valid in its strobe cycle.
- Addr keeps its last value in IDLE/RESP; it updates only on request acceptance.
- Memory_Ack in BOOT, IDLE or RESP is ignored: no state change, no response.
- Req_Valid while Req_Ready=0 is ignored. The requester must hold the request until accepted.
- Reset mid-transaction: the transaction is dropped with no Rsp_Valid, bus outputs return to reset values, and BOOT/ResetReq restarts for the full COPY_CYCLES.
- Counter widths: copy 16 bits, timeout 8 bits. There is no wrap-around inside a legal parameter range.

Test Plan:
1. COPY_CYCLES=8, Reset high 3 cycles then low -> ResetReq=1 and Req_Ready=0 for exactly 8 edges; then ResetReq=0, Copy_Busy=0, Req_Ready=1.
2. Read Req_Addr=0x8123, memory acks in LOAD with MemData_In=0x5A -> Addr=0x8123, Load pulse 1 cycle, Direction=0, Rsp_Valid at T+2, Rsp_RData=0x5A, Rsp_Error=0.
3. Write Req_Addr=0x0040, Req_WData=0xC3, ack after 3 wait cycles -> OE=1 and Direction=1 from T+1 through the ack cycle, MemData_Out=0xC3 stable, Rsp_Valid at T+5, OE=0 in RESP.
4. TIMEOUT=4, read never acked -> Rsp_Valid with Rsp_Error=1, Rsp_RData=0xFF after 4 WAIT_ACK cycles; a repeat with ack on the 4th cycle -> Rsp_Error=0 with valid data.
5. Reset asserted in WAIT_ACK -> no Rsp_Valid, Load/OE/Direction=0, ResetReq=1 for the full COPY_CYCLES, then a normal read succeeds.
6. Spurious Memory_Ack in IDLE and BOOT, plus back-to-back Req_Valid held high -> no spurious Rsp_Valid; second request accepted only at T+3 after the first response.

Source files
------------

// File: rtl/mem_bridge_master.sv
`timescale 1ns/1ps
// mem_bridge_master
// CPU-side initiator for the shadowed 64K main-memory bridge.
// After reset it holds ResetReq high for COPY_CYCLES cycles while the memory
// side copies the boot shadow. It then accepts one pipeline request at a time,
// runs one bus transaction for it, and returns exactly one response.
//
// Ports
//   Clock, Reset         : system clock, synchronous active-high reset
//   Req_*                : pipeline request (valid/ready handshake)
//   Rsp_*                : one-cycle response strobe with read data / error
//   Addr, MemData_Out,
//   MemData_OE           : bus address, write data and data-drive enable
//   MemData_In           : bus read data
//   MemBridge_Load       : one-cycle transaction start strobe
//   MemBridge_Direction  : 1 = write to memory, 0 = read
//   Memory_Ack           : memory completion
//   ResetReq, Copy_Busy  : shadow copy request / copy in progress
module mem_bridge_master #(
    parameter int COPY_CYCLES = 32768,
    parameter int TIMEOUT     = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [15:0] Req_Addr,
    input  logic [7:0]  Req_WData,
    output logic        Rsp_Valid,
    output logic [7:0]  Rsp_RData,
    output logic        Rsp_Error,
    output logic [15:0] Addr,
    output logic [7:0]  MemData_Out,
    output logic        MemData_OE,
    input  logic [7:0]  MemData_In,
    output logic        MemBridge_Load,
    output logic        MemBridge_Direction,
    input  logic        Memory_Ack,
    output logic        ResetReq,
    output logic        Copy_Busy
);

    // Terminal counts; both counters start at 0, so the last cycle is N-1.
    localparam logic [15:0] COPY_LAST    = 16'(COPY_CYCLES - 1);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_LOAD     = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t      state_r;
    logic [15:0] copy_cnt_r;
    logic [7:0]  timeout_cnt_r;
    logic [7:0]  ack_data_s;

    // Response data captured on a successful ack: bus data for reads, zero for writes.
    always_comb begin
        ack_data_s = 8'h00;
        if (MemBridge_Direction) begin
            ack_data_s = 8'h00;
        end else begin
            ack_data_s = MemData_In;
        end
    end

    // Transaction sequencer; every output is a register written here.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r             <= ST_BOOT;
            copy_cnt_r          <= 16'd0;
            timeout_cnt_r       <= 8'd0;
            Req_Ready           <= 1'b0;
            Rsp_Valid           <= 1'b0;
            Rsp_RData           <= 8'h00;
            Rsp_Error           <= 1'b0;
            Addr                <= 16'h0000;
            MemData_Out         <= 8'h00;
            MemData_OE          <= 1'b0;
            MemBridge_Load      <= 1'b0;
            MemBridge_Direction <= 1'b0;
            ResetReq            <= 1'b1;
            Copy_Busy           <= 1'b1;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    copy_cnt_r <= copy_cnt_r + 16'd1;
                    if (copy_cnt_r == COPY_LAST) begin
                        state_r   <= ST_IDLE;
                        ResetReq  <= 1'b0;
                        Copy_Busy <= 1'b0;
                        Req_Ready <= 1'b1;
                    end else begin
                        ResetReq  <= 1'b1;
                        Copy_Busy <= 1'b1;
                        Req_Ready <= 1'b0;
                    end
                end

                ST_IDLE: begin
                    if (Req_Valid) begin
                        Addr                <= Req_Addr;
                        MemData_Out         <= Req_WData;
                        MemBridge_Direction <= Req_Write;
                        MemData_OE          <= Req_Write;
                        MemBridge_Load      <= 1'b1;
                        Req_Ready           <= 1'b0;
                        state_r             <= ST_LOAD;
                    end else begin
                        Req_Ready <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    MemBridge_Load <= 1'b0;
                    timeout_cnt_r  <= 8'd0;
                    if (Memory_Ack) begin
                        Rsp_Valid           <= 1'b1;
                        Rsp_Error           <= 1'b0;
                        Rsp_RData           <= ack_data_s;
                        MemData_OE          <= 1'b0;
                        MemBridge_Direction <= 1'b0;
                        state_r             <= ST_RESP;
                    end else begin
                        state_r <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    // An ack arriving on the final timeout cycle still completes normally.
                    if (Memory_Ack) begin
                        Rsp_Valid           <= 1'b1;
                        Rsp_Error           <= 1'b0;
                        Rsp_RData           <= ack_data_s;
                        MemData_OE          <= 1'b0;
                        MemBridge_Direction <= 1'b0;
                        state_r             <= ST_RESP;
                    end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                        Rsp_Valid           <= 1'b1;
                        Rsp_Error           <= 1'b1;
                        Rsp_RData           <= 8'hFF;
                        MemData_OE          <= 1'b0;
                        MemBridge_Direction <= 1'b0;
                        state_r             <= ST_RESP;
                    end else begin
                        timeout_cnt_r <= timeout_cnt_r + 8'd1;
                    end
                end

                ST_RESP: begin
                    Rsp_Valid <= 1'b0;
                    Rsp_Error <= 1'b0;
                    Req_Ready <= 1'b1;
                    state_r   <= ST_IDLE;
                end

                default: begin
                    // Unreachable encoding: fall back to a full boot sequence.
                    state_r             <= ST_BOOT;
                    copy_cnt_r          <= 16'd0;
                    timeout_cnt_r       <= 8'd0;
                    Req_Ready           <= 1'b0;
                    Rsp_Valid           <= 1'b0;
                    Rsp_Error           <= 1'b0;
                    MemData_OE          <= 1'b0;
                    MemBridge_Load      <= 1'b0;
                    MemBridge_Direction <= 1'b0;
                    ResetReq            <= 1'b1;
                    Copy_Busy           <= 1'b1;
                end
            endcase
        end
    end

endmodule
